// File: rtl/md_pkg.sv
// md_pkg: MD op encodings and counter sizing shared by the MD unit and decoder
package md_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_OTH   = 3'd7
  } md_op_e;
  // clamped to 1 so single-cycle configurations still get a legal counter
  function automatic int md_cnt_w(input int m, input int d);
    int n;
    n = (m > d) ? m : d;
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/md_divcore.sv
// md_divcore: combinational signed/unsigned quotient and remainder
module md_divcore #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sgn_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             dz_o
);
  logic             na, nb, ovf;
  logic [WIDTH-1:0] ua, ub, uq, ur, min_v;
  assign min_v = {1'b1, {(WIDTH-1){1'b0}}};
  assign na    = sgn_i & a_i[WIDTH-1];
  assign nb    = sgn_i & b_i[WIDTH-1];
  assign ua    = na ? -a_i : a_i;
  assign ub    = nb ? -b_i : b_i;
  assign dz_o  = (b_i == '0);
  assign ovf   = sgn_i & (a_i == min_v) & (b_i == '1);
  assign uq    = dz_o ? '0 : ua / ub;
  assign ur    = dz_o ? '0 : ua % ub;
  // quotient truncates toward zero; remainder follows the dividend's sign
  assign q_o   = ovf ? min_v : ((na ^ nb) ? -uq : uq);
  assign r_o   = ovf ? '0 : (na ? -ur : ur);
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers and stall request
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = md_cnt_w(MULT_CYCLES, DIV_CYCLES);
  typedef enum logic {S_IDLE, S_BUSY} state_e;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               wr_q, wr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               sgn, is_md, is_div, accept, dz;
  logic [2*WIDTH-1:0] ax, bx, prod;
  logic [WIDTH-1:0]   quo, rem;
  assign sgn    = ~op[0];
  assign is_md  = ~op[2];
  assign is_div = op[1];
  assign accept = start & ~flush & (state_q == S_IDLE);
  // sign-extend to 2*WIDTH so the truncated product is the exact signed/unsigned result
  assign ax     = {{WIDTH{sgn & a[WIDTH-1]}}, a};
  assign bx     = {{WIDTH{sgn & b[WIDTH-1]}}, b};
  assign prod   = ax * bx;
  md_divcore #(.WIDTH(WIDTH)) u_div (
    .a_i(a), .b_i(b), .sgn_i(sgn), .q_o(quo), .r_o(rem), .dz_o(dz)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (accept && is_md) begin
      state_d = S_BUSY;
      cnt_d   = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
      res_d   = is_div ? {rem, quo} : prod;
      wr_d    = ~(is_div & dz);
    end else if (accept) begin
      hi_d = (op == MD_MTHI) ? a : hi_q;
      lo_d = (op == MD_MTLO) ? a : lo_q;
    end
    if (state_q == S_BUSY) begin
      state_d = (cnt_q == '0) ? S_IDLE : S_BUSY;
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      {hi_d, lo_d} = (cnt_q == '0 && wr_q) ? res_q : {hi_q, lo_q};
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy      = (state_q == S_BUSY);
  assign stall_req = busy | (start & is_md);
  assign hi        = hi_q;
  assign lo        = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit, default timing plus a 1-cycle configuration
module tb_md_unit;
  import md_pkg::*;
  logic        clk = 0, reset = 0, start = 0, start1 = 0, flush = 0;
  logic [2:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, stall_req, busy1, stall1;
  logic [31:0] hi, lo, hi1, lo1;
  int          chk = 0, pass = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush), .a(a), .b(b),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );
  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .flush(flush), .a(a), .b(b),
    .busy(busy1), .stall_req(stall1), .hi(hi1), .lo(lo1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) tick();
    chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass++;
    chk++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else pass++;
    chk++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else pass++;
    chk++; if (stall_req !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_req); else pass++;
    reset = 1;
    tick();
  endtask

  task automatic test_mult;
    int n;
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
    go(MD_MULT, 32'hFFFFFFFE, 32'd3);
    #1;
    chk++; if (stall_req !== 1'b1) $display("FAIL mult_stall got %b want 1", stall_req); else pass++;
    tick();
    start = 0; a = 32'h1234; b = 32'h5678;
    chk++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL mult_hold got %h_%h want 0_0", hi, lo); else pass++;
    wait_idle(n);
    chk++; if (n !== 5) $display("FAIL mult_busy_cycles got %0d want 5", n); else pass++;
    e = exp_q.pop_front();
    chk++; if ({hi, lo} !== e) $display("FAIL mult_result got %h want %h", {hi, lo}, e); else pass++;
  endtask

  task automatic test_div;
    int n;
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    go(MD_DIV, -32'sd7, 32'd2);
    tick();
    start = 0;
    wait_idle(n);
    chk++; if (n !== 10) $display("FAIL div_busy_cycles got %0d want 10", n); else pass++;
    e = exp_q.pop_front();
    chk++; if ({hi, lo} !== e) $display("FAIL div_result got %h want %h", {hi, lo}, e); else pass++;
    exp_q.push_back({32'h1, 32'h7FFFFFFC});
    go(MD_DIVU, -32'sd7, 32'd2);
    tick();
    start = 0;
    wait_idle(n);
    e = exp_q.pop_front();
    chk++; if ({hi, lo} !== e) $display("FAIL divu_result got %h want %h", {hi, lo}, e); else pass++;
  endtask

  task automatic test_corner;
    int n;
    exp_q.push_back({32'h0, 32'h80000000});
    go(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    tick();
    start = 0;
    wait_idle(n);
    e = exp_q.pop_front();
    chk++; if ({hi, lo} !== e) $display("FAIL div_min_result got %h want %h", {hi, lo}, e); else pass++;
    go(MD_MTHI, 32'd5, 32'd0);
    #1;
    chk++; if (stall_req !== 1'b0) $display("FAIL mthi_stall got %b want 0", stall_req); else pass++;
    tick();
    chk++; if (hi !== 32'd5 || busy !== 1'b0) $display("FAIL mthi got hi=%h busy=%b want 5 0", hi, busy); else pass++;
    go(MD_MTLO, 32'd9, 32'd0);
    tick();
    start = 0;
    chk++; if (lo !== 32'd9) $display("FAIL mtlo got %h want 9", lo); else pass++;
    exp_q.push_back({32'd5, 32'd9});
    go(MD_DIVU, 32'd100, 32'd0);
    tick();
    start = 0;
    wait_idle(n);
    chk++; if (n !== 10) $display("FAIL divz_busy_cycles got %0d want 10", n); else pass++;
    e = exp_q.pop_front();
    chk++; if ({hi, lo} !== e) $display("FAIL divz_result got %h want %h", {hi, lo}, e); else pass++;
  endtask

  task automatic test_flush;
    go(MD_MULT, 32'd7, 32'd7);
    flush = 1;
    #1;
    chk++; if (stall_req !== 1'b1) $display("FAIL flush_stall got %b want 1", stall_req); else pass++;
    tick();
    start = 0; flush = 0;
    chk++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else pass++;
    tick();
    chk++; if (hi !== 32'd5 || lo !== 32'd9 || busy !== 1'b0) $display("FAIL flush_hilo got %h_%h busy=%b want 5_9 0", hi, lo, busy); else pass++;
  endtask

  task automatic test_ignored;
    int n;
    exp_q.push_back({32'd2, 32'd14});
    go(MD_DIV, 32'd100, 32'd7);
    tick();
    start = 0;
    tick();
    go(MD_MULT, 32'd6, 32'd7);
    #1;
    chk++; if (stall_req !== 1'b1) $display("FAIL ignored_stall got %b want 1", stall_req); else pass++;
    tick();
    start = 0; flush = 1;
    tick();
    flush = 0;
    wait_idle(n);
    chk++; if (n !== 7) $display("FAIL ignored_remaining got %0d want 7", n); else pass++;
    e = exp_q.pop_front();
    chk++; if ({hi, lo} !== e) $display("FAIL ignored_result got %h want %h", {hi, lo}, e); else pass++;
    tick();
    chk++; if (busy !== 1'b0) $display("FAIL ignored_no_mult got busy=%b want 0", busy); else pass++;
  endtask

  task automatic test_random;
    int n;
    logic [31:0] x, y;
    logic signed [63:0] sp;
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom_range(1, 32'h7FFFFFFF);
      sp = $signed(x) * $signed(y);
      exp_q.push_back(sp);
      go(MD_MULT, x, y);
      tick();
      start = 0;
      wait_idle(n);
      e = exp_q.pop_front();
      chk++; if ({hi, lo} !== e) $display("FAIL rand_mult got %h want %h", {hi, lo}, e); else pass++;
      exp_q.push_back({32'h0, x} * {32'h0, y});
      go(MD_MULTU, x, y);
      tick();
      start = 0;
      wait_idle(n);
      e = exp_q.pop_front();
      chk++; if ({hi, lo} !== e) $display("FAIL rand_multu got %h want %h", {hi, lo}, e); else pass++;
      exp_q.push_back({x % y, x / y});
      go(MD_DIVU, x, y);
      tick();
      start = 0;
      wait_idle(n);
      e = exp_q.pop_front();
      chk++; if ({hi, lo} !== e) $display("FAIL rand_divu got %h want %h", {hi, lo}, e); else pass++;
    end
  endtask

  task automatic test_reset_mid;
    go(MD_DIV, 32'd1000, 32'd3);
    tick();
    start = 0;
    repeat (3) tick();
    reset = 0;
    tick();
    chk++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else pass++;
    chk++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL rmid_hilo got %h_%h want 0_0", hi, lo); else pass++;
    reset = 1;
    repeat (12) tick();
    chk++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) $display("FAIL rmid_late got %h_%h busy=%b want 0_0 0", hi, lo, busy); else pass++;
  endtask

  task automatic test_back_to_back;
    exp_q.push_back({32'h0, 32'd12});
    op = MD_MULT; a = 32'd3; b = 32'd4; start1 = 1;
    tick();
    start1 = 0;
    chk++; if (busy1 !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy1); else pass++;
    tick();
    e = exp_q.pop_front();
    chk++; if (busy1 !== 1'b0) $display("FAIL b2b_pulse got %b want 0", busy1); else pass++;
    chk++; if ({hi1, lo1} !== e) $display("FAIL b2b_mult got %h want %h", {hi1, lo1}, e); else pass++;
    op = MD_MTLO; a = 32'd7; start1 = 1;
    tick();
    start1 = 0;
    chk++; if (lo1 !== 32'd7 || hi1 !== 32'h0 || busy1 !== 1'b0) $display("FAIL b2b_mtlo got %h_%h busy=%b want 0_7 0", hi1, lo1, busy1); else pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_corner();
    test_flush();
    test_ignored();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit with HI/LO registers, sitting in the E stage of the pipelined MIPS core beside the ALU. It is driven by the decoder's MD operation code and start strobe. It models configurable multiply and divide latency with a busy interval and accepts mthi/mtlo writes. It suppresses operations cancelled by an exception flush and asserts a stall request that the hazard unit uses to hold mfhi/mflo and MD instructions in D.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 2.
- MULT_CYCLES, 5: busy cycles for mult/multu; must be ≥ 1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be ≥ 1.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  MD operation present in E this cycle.
- op  in  3  MULT, MULTU, DIV, DIVU, MTHI, MTLO, OTH.
- flush  in  1  exception/interrupt taken this cycle; cancels any start in the same cycle.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- busy  out  1  operation in progress.
- stall_req  out  1  combinational: busy | (start & op ∈ {MULT, MULTU, DIV, DIVU}).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Reset (reset==0 at an edge):
  - hi = 0, lo = 0, busy = 0, counter = 0, pending result cleared.
  - Reset overrides any in-flight operation; the result is discarded.
- A start is accepted only when start==1, flush==0 and busy==0. Otherwise it is ignored.
  - While busy, MTHI/MTLO starts are also ignored, since the hazard unit guarantees none arrive.
- Operation results on acceptance:
  - MULT: {hi, lo} ← signed a × signed b, as a 2·WIDTH-bit product.
  - MULTU: {hi, lo} ← unsigned a × unsigned b.
  - DIV: lo ← a/b with truncation toward zero. hi ← remainder, which takes the sign of a.
    - a = MIN, b = −1: lo = MIN, hi = 0.
  - DIVU: lo ← a/b, hi ← a mod b, both unsigned.
  - DIV or DIVU with b = 0: hi and lo are left unchanged. The full DIV_CYCLES busy interval still elapses.
  - MTHI: hi ← a at the accepting edge, no busy. MTLO: lo ← a, likewise.
  - OTH: no effect.
- Mult/div results are computed from operands latched at acceptance. Later changes to a and b have no effect.
- flush does not cancel an operation that is already busy; it has already committed.

## Timing
- State machine:
  - IDLE → BUSY on an accepted mult/div. The counter loads N−1, where N is MULT_CYCLES or DIV_CYCLES.
  - In BUSY, the counter decrements each cycle.
  - At the edge where the counter equals 0, hi/lo are written and the state returns to IDLE.
- Start sampled at edge t:
  - busy = 1 during cycles t+1 … t+N.
  - The new hi/lo are visible from cycle t+N+1, and busy = 0 in that same cycle.
- Back-to-back: a new start in cycle t+N+1 is accepted, so there is no dead cycle.
- MTHI/MTLO latency is 1: the value written at edge t is visible in cycle t+1.
- During BUSY, hi and lo hold their old values.
- stall_req rises combinationally in the start cycle, with no extra registered cycle.

## Structure
- Shared package md_pkg holds:
  - the op encodings: MULT = 0, MULTU = 1, DIV = 2, DIVU = 3, MTHI = 4, MTLO = 5, OTH = 7;
  - a counter-width function: clog2 of max(MULT_CYCLES, DIV_CYCLES).
- The decoder imports the same package.
- The result is computed behaviourally into a 2·WIDTH pending register at acceptance.
- There is one natural sub-module, md_divcore. It is combinational signed/unsigned quotient/remainder with the zero-divisor and MIN/−1 special cases.
- No other sub-modules.

## Test plan
- Signed multiply (WIDTH = 32): MULT, a = 0xFFFFFFFE (−2), b = 3.
  - busy is high for 5 cycles.
  - Cycle 6: hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. stall_req is high in the start cycle.
- Divide with signed/unsigned contrast: DIV, a = −7, b = 2 gives lo = 0xFFFFFFFD, hi = 0xFFFFFFFF after 10 busy cycles.
  - DIVU on the same operands gives lo = 0x7FFFFFFC, hi = 1.
- Corner divides:
  - DIV a = 0x80000000, b = 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
  - DIVU with b = 0 after MTHI 5 / MTLO 9 leaves hi = 5, lo = 9 after the busy interval.
- Flush and ignored starts:
  - MULT with flush = 1 in the same cycle: busy stays 0 and hi/lo are unchanged.
  - A MULT start while a DIV is busy is ignored; the DIV result lands on schedule.
- Reset mid-divide: reset = 0 at busy cycle 4 forces busy = 0 and hi = lo = 0 the next cycle. No late write-back occurs.
- Parameter sweep with MULT_CYCLES = 1, DIV_CYCLES = 1:
  - back-to-back MULT 3×4 then MTLO 7 gives lo = 12, then lo = 7;
  - busy pulses exactly 1 cycle.
